multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control unit that sequences the RV32I core datapath (PC, register file, ALU, data memory and the four datapath muxes) over several clock cycles per instruction.
- Holds the instruction register, decodes the opcode and steps through fetch, decode, execute, memory and writeback states.
- Stalls on a data-memory ready handshake and counts retired instructions.
- Replaces the purely combinational decode at the core top level.

## Interface
Parameters:
- XLEN, 32, datapath and instruction width
- INSTRET_W, 32, retired-instruction counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge
- instr  in  XLEN  instruction word from instruction memory (addressed by PC)
- mem_ready  in  1  data memory completion for the current dm_req
- ir_q  out  XLEN  instruction register contents
- rs1, rs2, rd  out  5 each  register fields of ir_q
- pc_we  out  1  PC load enable
- pc_sel  out  1  PC source: 0 = PC+4 adder, 1 = ALU result
- op1_sel  out  1  ALU operand 1: 0 = RF data1, 1 = PC
- op2_sel  out  1  ALU operand 2: 0 = RF data2, 1 = immediate
- alu_func3  out  3  ALU operation
- alu_subsra  out  1  ALU sub/sra modifier
- wb_sel  out  2  writeback source: 00 = ALU, 01 = DM, 10 = PC+4
- rf_we  out  1  register file write enable
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write (valid with dm_req)
- dm_ctrl  out  3  access size/sign (funct3)
- illegal  out  1  sticky illegal-opcode flag
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH: ir_q <= instr; go to DECODE.
- DECODE: classify ir_q[6:0]:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, JAL 1101111 go to EXECUTE.
  - Any other opcode is illegal (see Configuration).
- EXECUTE:
  - R, I: go to WB.
  - LOAD, STORE: go to MEM.
  - JAL: go to WB.
- MEM:
  - dm_req=1 (dm_we=1 for STORE) held until mem_ready=1 is sampled.
  - LOAD then goes to WB.
  - STORE retires and goes to FETCH.
- WB: rf_we=1 (suppressed when rd==0); retire; go to FETCH.
- Retire cycle: pc_we=1 and instret+1 (wraps at 2^INSTRET_W-1 to 0). pc_sel=1 for JAL only.
- Operand/ALU selects are driven from EXECUTE through the last state of the instruction and held stable:
  - R: op1=0, op2=0, alu_func3=funct3, alu_subsra=ir_q[30], wb_sel=00.
  - I: op1=0, op2=1, alu_func3=funct3, alu_subsra=ir_q[30] only when funct3=101, else 0; wb_sel=00.
  - LOAD/STORE: op1=0, op2=1, alu_func3=000, alu_subsra=0, dm_ctrl=funct3; LOAD wb_sel=01.
  - JAL: op1=1, op2=1, alu_func3=000, wb_sel=10, pc_sel=1.
- All control outputs are 0 in FETCH and DECODE except during the illegal-as-NOP retire.

## Timing
- Reset (reset=0 at a clk edge): state=FETCH, ir_q=0, illegal=0, instret=0. All control outputs 0 while reset is low.
- Reset asserted mid-instruction aborts it: no pc_we, rf_we or dm_req on the following cycle.
- Latency:
  - R/I/JAL: 4 cycles.
  - STORE: 4 cycles + (N-1) for N MEM cycles.
  - LOAD: 5 cycles + (N-1).
- mem_ready high in the first MEM cycle gives a single-cycle MEM.
- dm_req deasserts the cycle after mem_ready is sampled.
- mem_ready outside MEM is ignored.
- pc_we and rf_we are single-cycle pulses; PC and RF update on the edge ending that cycle.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE sets illegal=1 and enters TRAP.
  - TRAP holds all enables at 0 and never retires until reset.
- ILLEGAL_TRAP_EN undefined:
  - An illegal opcode retires as a NOP in DECODE (pc_we=1, pc_sel=0, instret+1) and returns to FETCH.
  - illegal is tied 0.

## Structure
- Package ctrl_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL)
  - wb_sel encodings (WB_ALU, WB_DM, WB_PC4)
- Sub-module ctrl_decode (combinational): takes ir_q and produces the instruction class and the static select/ALU fields.
- The top holds the FSM, ir_q and instret.

## Test plan
- Reset low for 2 cycles, then release with instr=0x002081B3 (add x3,x1,x2) -> rf_we pulse in cycle 4 with wb_sel=00 and rd=3; pc_we in the same cycle; instret=1.
- instr=0x0080A183 (lw x3,8(x1)), mem_ready low for 3 MEM cycles -> dm_req high for 4 cycles, dm_we=0, dm_ctrl=010; rf_we with wb_sel=01 one cycle after ready.
- instr=0x0030A423 (sw x3,8(x1)), mem_ready=1 immediately -> dm_req=dm_we=1 for 1 cycle, pc_we in the same cycle; no rf_we.
- instr=0x008000EF (jal x1,8) -> op1_sel=1, op2_sel=1, wb_sel=10, pc_sel=1, pc_we and rf_we in cycle 4.
- instr=0xFFFFFFFF:
  - With ILLEGAL_TRAP_EN: illegal=1, no further pc_we, instret unchanged.
  - Without: pc_we in cycle 2, instret+1.
- Assert reset during MEM of a load -> next cycle dm_req=0, state=FETCH, instret=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R     = 3'd0,
    CL_I     = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_JAL   = 3'd4,
    CL_ILL   = 3'd5
  } iclass_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Static per-instruction datapath selects, valid from EXECUTE onward.
  typedef struct packed {
    logic       op1_sel;
    logic       op2_sel;
    logic [2:0] alu_func3;
    logic       alu_subsra;
    logic [1:0] wb_sel;
    logic       pc_sel;
    logic [2:0] dm_ctrl;
  } sel_t;

  function automatic iclass_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:     return CL_R;
      OP_I:     return CL_I;
      OP_LOAD:  return CL_LOAD;
      OP_STORE: return CL_STORE;
      OP_JAL:   return CL_JAL;
      default:  return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the instruction register into class, register
// fields and the static operand/ALU/writeback selects.
import ctrl_pkg::*;

module ctrl_decode #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ir_i,
  output iclass_e         cls_o,
  output sel_t            sel_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o
);

  logic [2:0] funct3;
  logic       unused_ir;

  assign funct3    = ir_i[14:12];
  assign rs1_o     = ir_i[19:15];
  assign rs2_o     = ir_i[24:20];
  assign rd_o      = ir_i[11:7];
  assign unused_ir = ^{ir_i[XLEN-1:31], ir_i[29:25]};

  always_comb begin
    cls_o = classify(ir_i[6:0]);
    sel_o = '0;
    case (cls_o)
      CL_R: begin
        sel_o.alu_func3  = funct3;
        sel_o.alu_subsra = ir_i[30];
        sel_o.wb_sel     = WB_ALU;
      end
      CL_I: begin
        // Only SRAI uses bit 30; for other immediates it is part of the constant.
        sel_o.op2_sel    = 1'b1;
        sel_o.alu_func3  = funct3;
        sel_o.alu_subsra = (funct3 == 3'b101) ? ir_i[30] : 1'b0;
        sel_o.wb_sel     = WB_ALU;
      end
      CL_LOAD: begin
        sel_o.op2_sel = 1'b1;
        sel_o.wb_sel  = WB_DM;
        sel_o.dm_ctrl = funct3;
      end
      CL_STORE: begin
        sel_o.op2_sel = 1'b1;
        sel_o.dm_ctrl = funct3;
      end
      CL_JAL: begin
        sel_o.op1_sel = 1'b1;
        sel_o.op2_sel = 1'b1;
        sel_o.wb_sel  = WB_PC4;
        sel_o.pc_sel  = 1'b1;
      end
      default: sel_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: instruction register, sequencing, memory
// stall and retired-instruction counter. ILLEGAL_TRAP_EN selects trap vs NOP.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      instr,
  input  logic                 mem_ready,
  output logic [XLEN-1:0]      ir_q,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 op1_sel,
  output logic                 op2_sel,
  output logic [2:0]           alu_func3,
  output logic                 alu_subsra,
  output logic [1:0]           wb_sel,
  output logic                 rf_we,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [2:0]           dm_ctrl,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       ir_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  iclass_e               cls;
  sel_t                  sel;
  logic                  retire;
  logic                  sel_active;

  ctrl_decode #(.XLEN(XLEN)) u_decode (
    .ir_i  (ir_q),
    .cls_o (cls),
    .sel_o (sel),
    .rs1_o (rs1),
    .rs2_o (rs2),
    .rd_o  (rd)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      FETCH: begin
        ir_d    = instr;
        state_d = DECODE;
      end
      DECODE: begin
        if (cls == CL_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = TRAP;
`else
          retire  = 1'b1;
          state_d = FETCH;
`endif
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: state_d = (cls == CL_LOAD || cls == CL_STORE) ? MEM : WB;
      MEM: begin
        // Stall here until the data memory reports completion.
        if (mem_ready) begin
          if (cls == CL_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    instret_d = instret_q + INSTRET_W'(retire);
  end

  // Selects hold from EXECUTE to the end of the instruction; all control
  // outputs are forced low while reset is asserted so an abort is immediate.
  assign sel_active = reset &&
                      (state_q == EXECUTE || state_q == MEM || state_q == WB);

  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    op1_sel    = 1'b0;
    op2_sel    = 1'b0;
    alu_func3  = 3'b000;
    alu_subsra = 1'b0;
    wb_sel     = WB_ALU;
    rf_we      = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_ctrl    = 3'b000;
    if (sel_active) begin
      pc_sel     = sel.pc_sel;
      op1_sel    = sel.op1_sel;
      op2_sel    = sel.op2_sel;
      alu_func3  = sel.alu_func3;
      alu_subsra = sel.alu_subsra;
      wb_sel     = sel.wb_sel;
      dm_ctrl    = sel.dm_ctrl;
    end
    if (reset) begin
      pc_we  = retire;
      rf_we  = (state_q == WB) && (rd != 5'd0);
      dm_req = (state_q == MEM);
      dm_we  = (state_q == MEM) && (cls == CL_STORE);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; expected trap behaviour follows ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic [31:0] ir_q;
  logic [4:0]  rs1, rs2, rd;
  logic        pc_we, pc_sel, op1_sel, op2_sel, alu_subsra, rf_we, dm_req, dm_we, illegal;
  logic [2:0]  alu_func3, dm_ctrl;
  logic [1:0]  wb_sel;
  logic [31:0] instret;
  logic [15:0] ctl_v;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A183;
  localparam logic [31:0] I_SW   = 32'h0030A423;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_ADDI = 32'h40000013;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  multicycle_ctrl #(.XLEN(32), .INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .ir_q(ir_q), .rs1(rs1), .rs2(rs2), .rd(rd),
    .pc_we(pc_we), .pc_sel(pc_sel), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .alu_func3(alu_func3), .alu_subsra(alu_subsra), .wb_sel(wb_sel),
    .rf_we(rf_we), .dm_req(dm_req), .dm_we(dm_we), .dm_ctrl(dm_ctrl),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  assign ctl_v = {pc_we, pc_sel, op1_sel, op2_sel, alu_func3, alu_subsra,
                  wb_sel, rf_we, dm_req, dm_we, dm_ctrl};

  function automatic logic [15:0] ctl(input logic pcwe, input logic pcsel,
                                      input logic o1, input logic o2,
                                      input logic [2:0] f3, input logic sub,
                                      input logic [1:0] wb, input logic rf,
                                      input logic req, input logic we,
                                      input logic [2:0] dmc);
    return {pcwe, pcsel, o1, o2, f3, sub, wb, rf, req, we, dmc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Starts in a FETCH cycle, ends in the next instruction's FETCH cycle.
  task automatic exec4(input string tag, input logic [31:0] ins,
                       input logic [15:0] ex_c, input logic [15:0] wb_c,
                       input logic [31:0] ret);
    instr = ins;
    #1;
    check({tag, "_fetch"}, 32'(ctl_v), 32'd0);
    step();
    check({tag, "_ir"}, ir_q, ins);
    check({tag, "_decode"}, 32'(ctl_v), 32'd0);
    step();
    check({tag, "_ex"}, 32'(ctl_v), 32'(ex_c));
    step();
    check({tag, "_wb"}, 32'(ctl_v), 32'(wb_c));
    step();
    check({tag, "_instret"}, instret, ret);
    check({tag, "_next_fetch"}, 32'(ctl_v), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; instr = 32'd0; mem_ready = 1'b0;
    @(negedge clk); #1;
    check("rst_ctl_low", 32'(ctl_v), 32'd0);
    step(); step();
    check("rst_ctl", 32'(ctl_v), 32'd0);
    check("rst_ir", ir_q, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // add x3,x1,x2
    reset = 1'b1;
    exec4("add", I_ADD, 16'd0, ctl(1,0,0,0,3'b000,0,2'b00,1,0,0,3'b000), 32'd1);
    check("add_rd", 32'(rd), 32'd3);
    check("add_rs1", 32'(rs1), 32'd1);
    check("add_rs2", 32'(rs2), 32'd2);

    // lw x3,8(x1) with three wait cycles; ready in EXECUTE must be ignored
    instr = I_LW; #1;
    check("lw_fetch", 32'(ctl_v), 32'd0);
    step();
    check("lw_decode", 32'(ctl_v), 32'd0);
    step(); mem_ready = 1'b1; #1;
    check("lw_ex", 32'(ctl_v), 32'(ctl(0,0,0,1,3'b000,0,2'b01,0,0,0,3'b010)));
    for (int i = 0; i < 3; i++) begin
      step(); mem_ready = 1'b0; #1;
      check("lw_mem_wait", 32'(ctl_v), 32'(ctl(0,0,0,1,3'b000,0,2'b01,0,1,0,3'b010)));
    end
    step(); mem_ready = 1'b1; #1;
    check("lw_mem_rdy", 32'(ctl_v), 32'(ctl(0,0,0,1,3'b000,0,2'b01,0,1,0,3'b010)));
    step(); mem_ready = 1'b0; #1;
    check("lw_wb", 32'(ctl_v), 32'(ctl(1,0,0,1,3'b000,0,2'b01,1,0,0,3'b010)));
    step();
    check("lw_instret", instret, 32'd2);

    // sw x3,8(x1) with immediate ready
    instr = I_SW; #1;
    check("sw_fetch", 32'(ctl_v), 32'd0);
    step();
    check("sw_decode", 32'(ctl_v), 32'd0);
    step();
    check("sw_ex", 32'(ctl_v), 32'(ctl(0,0,0,1,3'b000,0,2'b00,0,0,0,3'b010)));
    step(); mem_ready = 1'b1; #1;
    check("sw_mem", 32'(ctl_v), 32'(ctl(1,0,0,1,3'b000,0,2'b00,0,1,1,3'b010)));
    step(); mem_ready = 1'b0; #1;
    check("sw_after", 32'(ctl_v), 32'd0);
    check("sw_instret", instret, 32'd3);

    exec4("jal", I_JAL, ctl(0,1,1,1,3'b000,0,2'b10,0,0,0,3'b000),
          ctl(1,1,1,1,3'b000,0,2'b10,1,0,0,3'b000), 32'd4);
    exec4("srai", I_SRAI, ctl(0,0,0,1,3'b101,1,2'b00,0,0,0,3'b000),
          ctl(1,0,0,1,3'b101,1,2'b00,1,0,0,3'b000), 32'd5);
    exec4("addi_x0", I_ADDI, ctl(0,0,0,1,3'b000,0,2'b00,0,0,0,3'b000),
          ctl(1,0,0,1,3'b000,0,2'b00,0,0,0,3'b000), 32'd6);
    exec4("sub", I_SUB, ctl(0,0,0,0,3'b000,1,2'b00,0,0,0,3'b000),
          ctl(1,0,0,0,3'b000,1,2'b00,1,0,0,3'b000), 32'd7);

    // illegal opcode
    instr = I_BAD; #1;
    check("bad_fetch", 32'(ctl_v), 32'd0);
    step();
`ifdef ILLEGAL_TRAP_EN
    check("bad_decode", 32'(ctl_v), 32'd0);
    step();
    check("bad_illegal", 32'(illegal), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bad_trap_ctl", 32'(ctl_v), 32'd0);
      step();
    end
    check("bad_instret", instret, 32'd7);
`else
    check("bad_decode", 32'(ctl_v), 32'(ctl(1,0,0,0,3'b000,0,2'b00,0,0,0,3'b000)));
    step();
    check("bad_after", 32'(ctl_v), 32'd0);
    check("bad_instret", instret, 32'd8);
    check("bad_illegal", 32'(illegal), 32'd0);
`endif

    // reset pulse clears sticky state
    reset = 1'b0; #1;
    check("rst2_ctl", 32'(ctl_v), 32'd0);
    step();
    check("rst2_instret", instret, 32'd0);
    check("rst2_illegal", 32'(illegal), 32'd0);
    check("rst2_ir", ir_q, 32'd0);
    reset = 1'b1;

    // reset asserted during MEM of a load
    exec4("add2", I_ADD, 16'd0, ctl(1,0,0,0,3'b000,0,2'b00,1,0,0,3'b000), 32'd1);
    instr = I_LW;
    step(); step(); step();
    check("abort_mem", 32'(dm_req), 32'd1);
    step(); reset = 1'b0; #1;
    check("abort_gated", 32'(ctl_v), 32'd0);
    step();
    check("abort_next", 32'(ctl_v), 32'd0);
    check("abort_instret", instret, 32'd0);
    reset = 1'b1;
    exec4("add3", I_ADD, 16'd0, ctl(1,0,0,0,3'b000,0,2'b00,1,0,0,3'b000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
